// File: rtl/wb_buffer_pkg.sv
// Shared definitions for the write-back victim buffer: line defaults, constant
// AXI write attributes and the drain FSM state encoding.
package wb_buffer_pkg;

  localparam int LINE_W_DEF = 128;
  localparam int ADDR_W     = 32;
  localparam int TAG_W      = 28;  // line address without the 16-byte offset

  localparam logic [2:0] WR_TYPE_LINE = 3'b100;
  localparam logic [3:0] WSTRB_FULL   = 4'b1111;

  typedef enum logic [1:0] {
    DS_IDLE      = 2'd0,
    DS_ISSUE     = 2'd1,
    DS_WAIT_BUSY = 2'd2,
    DS_WAIT_DONE = 2'd3
  } drain_state_e;

  // Line tag of a byte address (drops the offset within a 16-byte line).
  function automatic logic [TAG_W-1:0] line_tag(input logic [ADDR_W-1:0] addr);
    return addr[ADDR_W-1:4];
  endfunction

endpackage

// File: rtl/wb_fifo_mem.sv
// Victim-line storage: DEPTH entries of {line tag, line data}, one write port,
// every entry readable combinationally so the parent can search all of them.
module wb_fifo_mem
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = LINE_W_DEF,
  localparam int AW      = $clog2(DEPTH),
  localparam int ENTRY_W = TAG_W + LINE_W
) (
  input  logic                           clk,
  input  logic                           we_i,
  input  logic [AW-1:0]                  waddr_i,
  input  logic [ENTRY_W-1:0]             wdata_i,
  output logic [DEPTH-1:0][ENTRY_W-1:0]  rdata_o
);

  // Storage is deliberately not reset; validity is tracked by the parent.
  logic [ENTRY_W-1:0] mem_q [DEPTH];

  // Single write port.
  always_ff @(posedge clk) begin
    if (we_i) begin
      mem_q[waddr_i] <= wdata_i;
    end
  end

  // Expose every entry for the associative lookup and the head read.
  always_comb begin
    for (int i = 0; i < DEPTH; i++) begin
      rdata_o[i] = mem_q[i];
    end
  end

endmodule

// File: rtl/wb_buffer.sv
// Write-back buffer: holds dirty victim lines evicted by the dcache, drains
// them in FIFO order to the AXI bridge write port, and lets the dcache find a
// line that is still pending (youngest match wins).
//
// Handshakes:
//   push: a line transfers on a rising edge where push_valid && push_ready.
//         push_ready depends only on registered occupancy, so a pop in the
//         same cycle never frees room for a push into a full buffer.
//   write: wr_req is a one-cycle pulse; the bridge signals acceptance by
//         dropping wr_rdy and completion by raising it again, at which point
//         the head entry is retired. wr_addr/wr_data hold the head entry
//         throughout.
module wb_buffer
  import wb_buffer_pkg::*;
#(
  parameter int DEPTH  = 2,
  parameter int LINE_W = LINE_W_DEF
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               push_valid,
  output logic               push_ready,
  input  logic [31:0]        push_addr,
  input  logic [LINE_W-1:0]  push_data,
  input  logic [31:0]        lookup_addr,
  output logic               lookup_hit,
  output logic [LINE_W-1:0]  lookup_data,
  output logic               empty,
  output logic               wr_req,
  output logic [2:0]         wr_type,
  output logic [31:0]        wr_addr,
  output logic [3:0]         wr_wstrb,
  output logic [LINE_W-1:0]  wr_data,
  input  logic               wr_rdy,
  output drain_state_e       dbg_state
);

  localparam int PTR_W   = $clog2(DEPTH);
  localparam int CNT_W   = PTR_W + 1;
  localparam int ENTRY_W = TAG_W + LINE_W;

  logic [PTR_W-1:0] head_q, head_d;
  logic [PTR_W-1:0] tail_q, tail_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [DEPTH-1:0] valid_q, valid_d;
  drain_state_e     state_q, state_d;

  logic [DEPTH-1:0][ENTRY_W-1:0] entries;
  logic                          push_fire;
  logic                          pop_fire;
  logic [PTR_W-1:0]              lk_idx;
  logic                          unused_offset_bits;

  // The byte offset within a line never takes part in any comparison.
  assign unused_offset_bits = ^{push_addr[3:0], lookup_addr[3:0]};

  assign push_ready = (count_q < CNT_W'(DEPTH));
  assign push_fire  = push_valid && push_ready;

  wb_fifo_mem #(
    .DEPTH  (DEPTH),
    .LINE_W (LINE_W)
  ) u_mem (
    .clk     (clk),
    .we_i    (push_fire),
    .waddr_i (tail_q),
    .wdata_i ({line_tag(push_addr), push_data}),
    .rdata_o (entries)
  );

  // Drain FSM next state and the single-cycle write request.
  always_comb begin
    state_d  = state_q;
    wr_req   = 1'b0;
    pop_fire = 1'b0;
    case (state_q)
      DS_IDLE: begin
        if ((count_q != '0) && wr_rdy) state_d = DS_ISSUE;
      end
      DS_ISSUE: begin
        wr_req  = 1'b1;
        state_d = DS_WAIT_BUSY;
      end
      DS_WAIT_BUSY: begin
        if (!wr_rdy) state_d = DS_WAIT_DONE;
      end
      DS_WAIT_DONE: begin
        if (wr_rdy) begin
          state_d  = DS_IDLE;
          pop_fire = 1'b1;
        end
      end
      default: state_d = DS_IDLE;
    endcase
  end

  // Drain FSM state register.
  always_ff @(posedge clk) begin
    if (reset) state_q <= DS_IDLE;
    else       state_q <= state_d;
  end

  // FIFO bookkeeping: push at tail, pop at head, both may occur together.
  always_comb begin
    head_d  = head_q;
    tail_d  = tail_q;
    count_d = count_q;
    valid_d = valid_q;
    if (push_fire) begin
      tail_d          = tail_q + 1'b1;
      valid_d[tail_q] = 1'b1;
    end
    if (pop_fire) begin
      head_d          = head_q + 1'b1;
      valid_d[head_q] = 1'b0;
    end
    case ({push_fire, pop_fire})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  // FIFO pointer, occupancy and validity registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      head_q  <= '0;
      tail_q  <= '0;
      count_q <= '0;
      valid_q <= '0;
    end else begin
      head_q  <= head_d;
      tail_q  <= tail_d;
      count_q <= count_d;
      valid_q <= valid_d;
    end
  end

  // Associative search, oldest to youngest so the youngest match wins.
  always_comb begin
    lookup_hit  = 1'b0;
    lookup_data = '0;
    lk_idx      = head_q;
    for (int i = 0; i < DEPTH; i++) begin
      lk_idx = head_q + PTR_W'(i);
      if (valid_q[lk_idx] &&
          (entries[lk_idx][ENTRY_W-1 -: TAG_W] == line_tag(lookup_addr))) begin
        lookup_hit  = 1'b1;
        lookup_data = entries[lk_idx][LINE_W-1:0];
      end
    end
  end

  assign wr_addr   = {entries[head_q][ENTRY_W-1 -: TAG_W], 4'b0000};
  assign wr_data   = entries[head_q][LINE_W-1:0];
  assign wr_type   = WR_TYPE_LINE;
  assign wr_wstrb  = WSTRB_FULL;
  assign empty     = (count_q == '0) && (state_q == DS_IDLE);
  assign dbg_state = state_q;

endmodule

// File: tb/tb_wb_buffer.sv
// Directed bench for wb_buffer: a scoreboard queue of expected write-outs fed
// at push time and drained by a monitor on every wr_req, plus directed checks
// of latency, lookup, back-pressure and reset behaviour.
module tb_wb_buffer;
  import wb_buffer_pkg::*;

  localparam int DEPTH  = 2;
  localparam int LINE_W = 128;

  localparam logic [127:0] D1 = 128'h1111_0001_2222_0002_3333_0003_4444_0004;
  localparam logic [127:0] DB1 = 128'hB1B1_0000_0000_0000_0000_0000_0000_00B1;
  localparam logic [127:0] DB2 = 128'hB2B2_0000_0000_0000_0000_0000_0000_00B2;
  localparam logic [127:0] DB3 = 128'hB3B3_0000_0000_0000_0000_0000_0000_00B3;
  localparam logic [127:0] D4 = 128'h4444_4444_0000_0000_0000_0000_DEAD_BEEF;
  localparam logic [127:0] D5 = 128'h5555_5555_0000_0000_0000_0000_CAFE_F00D;
  localparam logic [127:0] DE1 = 128'hE1E1_E1E1_E1E1_E1E1_0000_0000_0000_0001;
  localparam logic [127:0] DE2 = 128'hE2E2_E2E2_E2E2_E2E2_0000_0000_0000_0002;
  localparam logic [127:0] DF1 = 128'hF1F1_0000_0000_0000_0000_0000_0000_0F01;
  localparam logic [127:0] DF2 = 128'hF2F2_0000_0000_0000_0000_0000_0000_0F02;
  localparam logic [127:0] DG  = 128'h6060_6060_6060_6060_6060_6060_6060_6060;

  logic               clk;
  logic               reset;
  logic               push_valid;
  logic               push_ready;
  logic [31:0]        push_addr;
  logic [LINE_W-1:0]  push_data;
  logic [31:0]        lookup_addr;
  logic               lookup_hit;
  logic [LINE_W-1:0]  lookup_data;
  logic               empty;
  logic               wr_req;
  logic [2:0]         wr_type;
  logic [31:0]        wr_addr;
  logic [3:0]         wr_wstrb;
  logic [LINE_W-1:0]  wr_data;
  logic               wr_rdy;
  drain_state_e       dbg_state;

  int n_tests;
  int n_fail;
  int req_count;
  int rc_snap;
  logic prev_req;
  logic [159:0] exp_q[$];
  logic [159:0] mon_e;

  wb_buffer #(.DEPTH(DEPTH), .LINE_W(LINE_W)) dut (
    .clk         (clk),
    .reset       (reset),
    .push_valid  (push_valid),
    .push_ready  (push_ready),
    .push_addr   (push_addr),
    .push_data   (push_data),
    .lookup_addr (lookup_addr),
    .lookup_hit  (lookup_hit),
    .lookup_data (lookup_data),
    .empty       (empty),
    .wr_req      (wr_req),
    .wr_type     (wr_type),
    .wr_addr     (wr_addr),
    .wr_wstrb    (wr_wstrb),
    .wr_data     (wr_data),
    .wr_rdy      (wr_rdy),
    .dbg_state   (dbg_state)
  );

  // Clock and watchdog.
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_tests++;
    n_fail++;
    $display("FAIL %s", name);
  endtask

  // Driver tasks.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic neg();
    @(negedge clk);
  endtask

  task automatic drive_push(input logic [31:0] a, input logic [127:0] d);
    push_valid = 1'b1;
    push_addr  = a;
    push_data  = d;
    exp_q.push_back({a[31:4], 4'h0, d});
  endtask

  task automatic wait_req(input string name);
    int k;
    k = 0;
    neg();
    while (!wr_req && k < 40) begin
      neg();
      k++;
    end
    if (!wr_req) fail_now(name);
  endtask

  // Bridge model: accept the burst, stay busy two cycles, then complete.
  task automatic drain_one();
    wait_req("drain wr_req timeout");
    tick();
    wr_rdy = 1'b0;
    tick();
    tick();
    wr_rdy = 1'b1;
    tick();
  endtask

  // Scoreboard monitor: every write request must match the oldest expected line.
  initial begin
    prev_req  = 1'b0;
    req_count = 0;
    forever begin
      @(negedge clk);
      if (wr_req) begin
        req_count++;
        check("wr_req pulse width", {127'b0, prev_req}, 128'd0);
        if (exp_q.size() == 0) begin
          fail_now("unexpected wr_req");
        end else begin
          mon_e = exp_q.pop_front();
          check("wr_addr", {96'b0, wr_addr}, {96'b0, mon_e[159:128]});
          check("wr_data", wr_data, mon_e[127:0]);
          check("wr_type", {125'b0, wr_type}, 128'd4);
          check("wr_wstrb", {124'b0, wr_wstrb}, 128'hF);
        end
      end
      prev_req = wr_req;
    end
  end

  // Directed sequence.
  initial begin
    n_tests     = 0;
    n_fail      = 0;
    reset       = 1'b1;
    push_valid  = 1'b0;
    push_addr   = '0;
    push_data   = '0;
    lookup_addr = '0;
    wr_rdy      = 1'b1;
    tick();
    tick();
    neg();
    check("reset wr_req", wr_req, 0);
    check("reset push_ready", push_ready, 1);
    check("reset lookup_hit", lookup_hit, 0);
    check("reset lookup_data", lookup_data, 0);
    check("reset empty", empty, 1);
    check("reset wr_type", wr_type, 128'h4);
    check("reset wr_wstrb", wr_wstrb, 128'hF);
    check("reset state", dbg_state, DS_IDLE);
    tick();
    reset = 1'b0;

    // Single push, minimum latency, pop and lookup around WAIT_DONE.
    lookup_addr = 32'h1000_0048;
    drive_push(32'h1000_0040, D1);
    neg();
    check("t1 no same-cycle forward", lookup_hit, 0);
    check("t1 wr_req cycle N", wr_req, 0);
    tick();
    push_valid = 1'b0;
    neg();
    check("t1 hit after push", lookup_hit, 1);
    check("t1 hit data", lookup_data, D1);
    check("t1 wr_req cycle N+1", wr_req, 0);
    check("t1 not empty", empty, 0);
    tick();
    neg();
    check("t1 wr_req cycle N+2", wr_req, 1);
    check("t1 wr_addr", wr_addr, 128'h1000_0040);
    tick();
    wr_rdy = 1'b0;
    neg();
    check("t1 wr_req drops", wr_req, 0);
    check("t1 state wait_busy", dbg_state, DS_WAIT_BUSY);
    tick();
    neg();
    check("t1 state wait_done", dbg_state, DS_WAIT_DONE);
    check("t1 hit in wait_done", lookup_hit, 1);
    check("t1 addr stable", wr_addr, 128'h1000_0040);
    tick();
    wr_rdy = 1'b1;
    neg();
    check("t1 hit on pop cycle", lookup_hit, 1);
    tick();
    neg();
    check("t1 hit after pop", lookup_hit, 0);
    check("t1 data zero after pop", lookup_data, 0);
    check("t1 empty after pop", empty, 1);

    // Back-to-back pushes against a busy bridge; third is held off.
    tick();
    wr_rdy = 1'b0;
    drive_push(32'h3000_0100, DB1);
    tick();
    drive_push(32'h3000_0204, DB2);
    neg();
    check("t2 ready with one entry", push_ready, 1);
    tick();
    drive_push(32'h3000_030C, DB3);
    neg();
    check("t2 full after two", push_ready, 0);
    tick();
    neg();
    check("t2 still full", push_ready, 0);
    check("t2 no req while busy", wr_req, 0);
    wr_rdy = 1'b1;
    drain_one();
    neg();
    check("t2 ready after pop", push_ready, 1);
    tick();
    push_valid = 1'b0;
    drain_one();
    drain_one();
    neg();
    check("t2 empty after drain", empty, 1);

    // Youngest-match lookup over overlapping lines.
    tick();
    wr_rdy      = 1'b0;
    lookup_addr = 32'h2000_0010;
    drive_push(32'h2000_0010, D4);
    neg();
    check("t3 same-cycle push hidden", lookup_hit, 0);
    tick();
    drive_push(32'h2000_001C, D5);
    lookup_addr = 32'h2000_0014;
    neg();
    check("t3 older entry only", lookup_data, D4);
    tick();
    push_valid = 1'b0;
    neg();
    check("t3 hit", lookup_hit, 1);
    check("t3 youngest data", lookup_data, D5);
    lookup_addr = 32'h2000_0020;
    #1;
    check("t3 miss", lookup_hit, 0);
    check("t3 miss data zero", lookup_data, 0);
    wr_rdy = 1'b1;
    drain_one();
    drain_one();

    // Push on the pop cycle with one entry pending.
    drive_push(32'h4000_0080, DE1);
    tick();
    push_valid = 1'b0;
    wait_req("t4 wr_req timeout");
    tick();
    wr_rdy = 1'b0;
    tick();
    wr_rdy = 1'b1;
    drive_push(32'h4000_00C0, DE2);
    neg();
    check("t4 ready on pop cycle", push_ready, 1);
    tick();
    push_valid = 1'b0;
    neg();
    check("t4 one entry left", push_ready, 1);
    check("t4 not empty", empty, 0);
    lookup_addr = 32'h4000_0080;
    #1;
    check("t4 popped line gone", lookup_hit, 0);
    lookup_addr = 32'h4000_00C0;
    #1;
    check("t4 new line present", lookup_hit, 1);
    check("t4 new line data", lookup_data, DE2);
    drain_one();
    neg();
    check("t4 empty after drain", empty, 1);

    // Reset while a burst is outstanding with two entries held.
    tick();
    wr_rdy = 1'b0;
    drive_push(32'h5000_0000, DF1);
    tick();
    drive_push(32'h5000_0010, DF2);
    tick();
    push_valid  = 1'b0;
    lookup_addr = 32'h5000_0010;
    wr_rdy      = 1'b1;
    wait_req("t5 wr_req timeout");
    tick();
    neg();
    check("t5 in wait_busy", dbg_state, DS_WAIT_BUSY);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    neg();
    check("t5 empty after reset", empty, 1);
    check("t5 no wr_req after reset", wr_req, 0);
    check("t5 ready after reset", push_ready, 1);
    check("t5 lookup cleared", lookup_hit, 0);
    exp_q.delete();
    rc_snap = req_count;
    repeat (10) tick();
    neg();
    check("t5 no further requests", req_count, rc_snap);

    // Recovery after reset.
    tick();
    drive_push(32'h6000_0030, DG);
    tick();
    push_valid = 1'b0;
    drain_one();
    neg();
    check("t6 empty after drain", empty, 1);

    check("scoreboard drained", exp_q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
